// File: rtl/pos_shift_pkg.sv
// Shared types and helpers for the one-hot position register.
// Optional input synchronizers are enabled with `define POS_SHIFT_SYNC_EN.
package pos_shift_pkg;

  // Largest position count the one-hot helper can build.
  localparam int MAX_POS = 256;

  typedef enum logic [1:0] {
    MV_NONE,
    MV_LEFT,
    MV_RIGHT,
    MV_HOME
  } move_e;

  // Width of a binary position index for n positions (at least 1 bit).
  function automatic int pos_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One-hot vector with bit idx set; all zeros if idx is out of range.
  function automatic logic [MAX_POS-1:0] onehot_of(input int unsigned idx,
                                                   input int unsigned n);
    logic [MAX_POS-1:0] v;
    v = '0;
    if (idx < n) v = MAX_POS'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/pos_shift_reg_edge_rise.sv
// Single-bit rising-edge detector with its own history flop.
// With `define POS_SHIFT_SYNC_EN the input first passes a 2-flop synchronizer.
module edge_rise
  import pos_shift_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic smp;
  logic hist_p0;

`ifdef POS_SHIFT_SYNC_EN
  logic sync_p0;
  logic sync_p1;

  // Two-flop synchronizer for inputs asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  assign smp = sync_p1;
`else
  assign smp = din;
`endif

  // History starts at 0 so an input already high at reset release is an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_p0 <= 1'b0;
    else        hist_p0 <= smp;
  end

  // ---- stage boundary: edge is combinational from the current sample ----
  assign rise = smp & ~hist_p0;

endmodule

// File: rtl/pos_shift_reg.sv
// Parametrised one-hot position register stepping left/right on request edges.
// Optional input synchronizers are enabled with `define POS_SHIFT_SYNC_EN.
module pos_shift_reg
  import pos_shift_pkg::*;
#(
  parameter int N_POS    = 4,
  parameter int HOME_POS = 0,
  parameter int WRAP     = 0,
  parameter int CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     left,
  input  logic                     right,
  input  logic                     first_pos,
  output logic [N_POS-1:0]         set,
  output logic [$clog2(N_POS)-1:0] pos,
  output logic                     at_min,
  output logic                     at_max,
  output logic                     blocked,
  output logic [CNT_W-1:0]         move_cnt
);

  localparam int               PW       = pos_w(N_POS);
  localparam logic [PW-1:0]    MAX_IDX  = PW'(N_POS - 1);
  localparam logic [PW-1:0]    HOME_IDX = PW'(HOME_POS);
  localparam logic [N_POS-1:0] HOME_SET = N_POS'(onehot_of(HOME_POS, N_POS));
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic rise_l;
  logic rise_r;
  logic rise_h;

  edge_rise u_edge_left  (.clk(clk), .rst_n(rst_n), .din(left),      .rise(rise_l));
  edge_rise u_edge_right (.clk(clk), .rst_n(rst_n), .din(right),     .rise(rise_r));
  edge_rise u_edge_home  (.clk(clk), .rst_n(rst_n), .din(first_pos), .rise(rise_h));

  move_e            mv;
  logic [PW-1:0]    pos_p0;
  logic [N_POS-1:0] set_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             blk_p0;

  logic [PW-1:0]    pos_nxt;
  logic [N_POS-1:0] set_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             blk_nxt;
  logic [N_POS-1:0] dec;
  logic             illegal;
  logic             accept;

  // Priority decode: home wins, simultaneous left+right cancel each other.
  always_comb begin
    mv = MV_NONE;
    if (rise_h)                 mv = MV_HOME;
    else if (rise_l && !rise_r) mv = MV_LEFT;
    else if (rise_r && !rise_l) mv = MV_RIGHT;
  end

  // Next position, blocked pulse and saturating move counter.
  always_comb begin
    pos_nxt = pos_p0;
    cnt_nxt = cnt_p0;
    blk_nxt = 1'b0;
    accept  = 1'b0;
    dec     = N_POS'(onehot_of(32'(pos_p0), N_POS));
    // A set vector that disagrees with pos, or an out-of-range pos, is illegal.
    illegal = (set_p0 != dec) || (dec == '0);
    if (mv == MV_HOME) begin
      pos_nxt = HOME_IDX;
      cnt_nxt = '0;
    end else if (illegal) begin
      pos_nxt = HOME_IDX;
    end else begin
      case (mv)
        MV_RIGHT: begin
          if (pos_p0 == MAX_IDX) begin
            if (WRAP != 0) begin
              pos_nxt = '0;
              accept  = 1'b1;
            end else begin
              blk_nxt = 1'b1;
            end
          end else begin
            pos_nxt = pos_p0 + PW'(1);
            accept  = 1'b1;
          end
        end
        MV_LEFT: begin
          if (pos_p0 == '0) begin
            if (WRAP != 0) begin
              pos_nxt = MAX_IDX;
              accept  = 1'b1;
            end else begin
              blk_nxt = 1'b1;
            end
          end else begin
            pos_nxt = pos_p0 - PW'(1);
            accept  = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (accept && (cnt_p0 != CNT_MAX)) cnt_nxt = cnt_p0 + CNT_W'(1);
    set_nxt = N_POS'(onehot_of(32'(pos_nxt), N_POS));
  end

  // ---- stage boundary: position state registers ----
  // pos and set load together so the one-hot never lags the index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_p0 <= HOME_IDX;
      set_p0 <= HOME_SET;
      cnt_p0 <= '0;
      blk_p0 <= 1'b0;
    end else begin
      pos_p0 <= pos_nxt;
      set_p0 <= set_nxt;
      cnt_p0 <= cnt_nxt;
      blk_p0 <= blk_nxt;
    end
  end

  assign set      = set_p0;
  assign pos      = pos_p0;
  assign at_min   = (pos_p0 == '0);
  assign at_max   = (pos_p0 == MAX_IDX);
  assign blocked  = blk_p0;
  assign move_cnt = cnt_p0;

endmodule

// File: tb/tb_pos_shift_reg.sv
// Self-checking bench: three configurations driven by shared stimulus,
// each compared every cycle against an arithmetic reference model.
module tb_pos_shift_reg;

`ifdef POS_SHIFT_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic left;
  logic right;
  logic first_pos;

  logic [3:0] set0, set1;
  logic [1:0] pos0, pos1;
  logic [7:0] set2;
  logic [2:0] pos2;
  logic       amin0, amax0, blk0, amin1, amax1, blk1, amin2, amax2, blk2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pos_shift_reg #(.N_POS(4), .HOME_POS(0), .WRAP(1), .CNT_W(8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .left(left), .right(right), .first_pos(first_pos),
    .set(set0), .pos(pos0), .at_min(amin0), .at_max(amax0), .blocked(blk0), .move_cnt(cnt0));

  pos_shift_reg #(.N_POS(4), .HOME_POS(0), .WRAP(0), .CNT_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .left(left), .right(right), .first_pos(first_pos),
    .set(set1), .pos(pos1), .at_min(amin1), .at_max(amax1), .blocked(blk1), .move_cnt(cnt1));

  pos_shift_reg #(.N_POS(8), .HOME_POS(5), .WRAP(1), .CNT_W(2)) u_big (
    .clk(clk), .rst_n(rst_n), .left(left), .right(right), .first_pos(first_pos),
    .set(set2), .pos(pos2), .at_min(amin2), .at_max(amax2), .blocked(blk2), .move_cnt(cnt2));

  // Reference model state, one entry per instance.
  int m_n[3]    = '{4, 4, 8};
  int m_home[3] = '{0, 0, 5};
  int m_wrap[3] = '{1, 0, 1};
  int m_cmax[3] = '{255, 255, 3};
  int m_pos[3];
  int m_cnt[3];
  int m_blk[3];
  bit hl[4], hr[4], hh[4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pos[i] = m_home[i];
      m_cnt[i] = 0;
      m_blk[i] = 0;
    end
    for (int k = 0; k < 4; k++) begin
      hl[k] = 0; hr[k] = 0; hh[k] = 0;
    end
  endtask

  // One accepted move: add a step with optional wrap, count with saturation.
  task automatic model_move(input int i, input int dir);
    int np;
    np = m_pos[i] + dir;
    if (np < 0 || np >= m_n[i]) begin
      if (m_wrap[i] != 0) begin
        m_pos[i] = (np + m_n[i]) % m_n[i];
        if (m_cnt[i] < m_cmax[i]) m_cnt[i]++;
      end else begin
        m_blk[i] = 1;
      end
    end else begin
      m_pos[i] = np;
      if (m_cnt[i] < m_cmax[i]) m_cnt[i]++;
    end
  endtask

  task automatic model_step();
    bit el, er, eh;
    for (int k = 3; k > 0; k--) begin
      hl[k] = hl[k-1]; hr[k] = hr[k-1]; hh[k] = hh[k-1];
    end
    hl[0] = left; hr[0] = right; hh[0] = first_pos;
    el = hl[D] && !hl[D+1];
    er = hr[D] && !hr[D+1];
    eh = hh[D] && !hh[D+1];
    for (int i = 0; i < 3; i++) begin
      m_blk[i] = 0;
      if (eh) begin
        m_pos[i] = m_home[i];
        m_cnt[i] = 0;
      end else if (el && er) begin
        // cancel
      end else if (er) begin
        model_move(i, 1);
      end else if (el) begin
        model_move(i, -1);
      end
    end
  endtask

  task automatic chk_inst(input int i, input logic [31:0] s, input logic [31:0] p,
                          input logic mn, input logic mx, input logic b, input logic [31:0] c);
    chk($sformatf("u%0d.set", i), s, 32'(1) << m_pos[i]);
    chk($sformatf("u%0d.pos", i), p, 32'(m_pos[i]));
    chk($sformatf("u%0d.at_min", i), 32'(mn), 32'(m_pos[i] == 0));
    chk($sformatf("u%0d.at_max", i), 32'(mx), 32'(m_pos[i] == m_n[i] - 1));
    chk($sformatf("u%0d.blocked", i), 32'(b), 32'(m_blk[i]));
    chk($sformatf("u%0d.move_cnt", i), c, 32'(m_cnt[i]));
  endtask

  task automatic check_all();
    chk_inst(0, 32'(set0), 32'(pos0), amin0, amax0, blk0, 32'(cnt0));
    chk_inst(1, 32'(set1), 32'(pos1), amin1, amax1, blk1, 32'(cnt1));
    chk_inst(2, 32'(set2), 32'(pos2), amin2, amax2, blk2, 32'(cnt2));
  endtask

  // Drive inputs at the falling edge, advance the model on the rising edge,
  // check outputs at the next falling edge.
  task automatic cyc(input logic l, input logic r, input logic h);
    left = l; right = r; first_pos = h;
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    @(negedge clk);
    check_all();
  endtask

  task automatic pulse(input logic l, input logic r, input logic h);
    cyc(l, r, h);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    left = 1'b0; right = 1'b0; first_pos = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();
    check_all();

    // Four right pulses from home.
    for (int k = 0; k < 4; k++) pulse(1'b0, 1'b1, 1'b0);
    settle();
    chk("wrap4.pos", 32'(pos0), 32'd0);
    chk("wrap4.cnt", 32'(cnt0), 32'd4);
    chk("sat4.pos", 32'(pos1), 32'd3);
    chk("sat4.cnt", 32'(cnt1), 32'd3);
    chk("big4.pos", 32'(pos2), 32'd1);
    chk("big4.cnt", 32'(cnt2), 32'd3);
    pulse(1'b0, 1'b1, 1'b0);
    settle();
    chk("big5.pos", 32'(pos2), 32'd2);
    chk("sat5.pos", 32'(pos1), 32'd3);

    // Left at index 0 on the saturating instance.
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    settle();
    chk("satL.pos", 32'(pos1), 32'd0);
    chk("wrapL.pos", 32'(pos0), 32'd3);

    // Held-high right gives one step.
    do_reset();
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 1'b0);
    settle();
    chk("hold.pos", 32'(pos0), 32'd1);
    chk("hold.cnt", 32'(cnt0), 32'd1);

    // Left and right together cancel.
    do_reset();
    pulse(1'b1, 1'b1, 1'b0);
    settle();
    chk("lr.pos", 32'(pos0), 32'd0);
    chk("lr.cnt", 32'(cnt0), 32'd0);

    // first_pos with right at position 2.
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    settle();
    chk("pre_home.pos", 32'(pos0), 32'd2);
    pulse(1'b0, 1'b1, 1'b1);
    settle();
    chk("home.pos", 32'(pos0), 32'd0);
    chk("home.cnt", 32'(cnt0), 32'd0);
    chk("home.big", 32'(pos2), 32'd5);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      logic l, r, h;
      l = ($urandom_range(0, 99) < 30) ? ~left  : left;
      r = ($urandom_range(0, 99) < 30) ? ~right : right;
      h = ($urandom_range(0, 99) < 4);
      cyc(l, r, h);
    end
    settle();

    // Asynchronous reset between clock edges at position 2.
    do_reset();
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    settle();
    chk("arst_pre.pos", 32'(pos0), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.set0", 32'(set0), 32'd1);
    chk("arst.set2", 32'(set2), 32'd32);
    check_all();
    @(negedge clk);
    cyc(1'b0, 1'b1, 1'b0);
    // Right already high at release must still count as an edge.
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0);
    chk("rel.pos", 32'(pos0), 32'd1);

    // Latency: output must change exactly D+1 cycles after the input rises.
    do_reset();
    settle();
    left = 1'b0; right = 1'b1; first_pos = 1'b0;
    for (int k = 0; k <= D; k++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk($sformatf("lat.c%0d", k), 32'(pos0), (k == D) ? 32'd1 : 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pos_shift_reg.md
Name: pos_shift_reg

Overview:
- Parametrised one-hot position register. A single active position steps left or right across N_POS outputs on rising edges of `left` / `right` request lines.
- `first_pos` returns the position to home.
- Generalises the fixed 4-output left/right position register:
  - N positions instead of a fixed 4.
  - Wrap or saturate mode.
  - Synchronous clocked operation with edge detection.
  - Blocked-move flag and move counter.
- Sits between button/step request logic and display/select decoders.

Parameters:
- N_POS, 4, number of positions (>=2).
- HOME_POS, 0, index loaded at reset and on `first_pos` (0..N_POS-1).
- WRAP, 0, 1 = moves wrap around the ends; 0 = moves saturate at the ends.
- CNT_W, 8, width of the move counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- left  in  1  level request; each rising edge requests one step toward index 0.
- right  in  1  level request; each rising edge requests one step toward index N_POS-1.
- first_pos  in  1  level; each rising edge returns the position to HOME_POS.
- set  out  N_POS  one-hot position; bit i high = position i.
- pos  out  $clog2(N_POS)  binary index of the active position.
- at_min  out  1  pos == 0.
- at_max  out  1  pos == N_POS-1.
- blocked  out  1  one-cycle pulse: a saturated move was refused.
- move_cnt  out  CNT_W  count of accepted moves since reset or home.

Behaviour:
- Reset (rst_n low, asynchronous):
  - set = one-hot at HOME_POS; pos = HOME_POS; at_min/at_max decoded from HOME_POS.
  - blocked = 0; move_cnt = 0.
  - Edge-detect history registers = 0, so an input already high at reset release counts as a rising edge.
- Edge detect:
  - A rising edge is input==1 while the previous registered sample==0.
  - The action takes effect on the same clk edge that first samples the input high, so outputs change 1 cycle after the input is applied.
  - A held-high input produces exactly one action.
- Priority per cycle:
  1. first_pos edge: load HOME_POS, clear move_cnt, blocked = 0. Any simultaneous left/right edge is ignored.
  2. left and right edges in the same cycle: no move, no count, blocked = 0.
  3. Single left or right edge: perform the move.
  4. No edge: hold.
- Move:
  - right: pos+1.
  - left: pos-1.
  - set is always the one-hot of pos. They are updated together, never out of step.
- End conditions:
  - WRAP=1: right at N_POS-1 goes to 0; left at 0 goes to N_POS-1. The move is accepted and counted; blocked stays 0.
  - WRAP=0: right at N_POS-1, or left at 0, leaves pos unchanged. blocked = 1 for one cycle; move_cnt is unchanged.
- move_cnt: +1 per accepted move; saturates at 2^CNT_W-1 (no wrap).
- Invariant: exactly one bit of set is high at all times outside reset. Any illegal state is corrected to HOME_POS on the next clock.
- Reset asserted mid-operation: immediate return to the reset values. Pending edges are lost.

Optional Feature:
- Macro: POS_SHIFT_SYNC_EN.
- Defined:
  - left, right and first_pos each pass through a 2-flop synchronizer (reset to 0) before edge detection.
  - Input-to-output latency becomes 3 cycles.
  - Inputs may be fully asynchronous to clk.
- Undefined:
  - No synchronizers; inputs must be synchronous to clk.
  - Latency is 1 cycle.

Decomposition:
- pos_shift_pkg:
  - Typedef `move_e` {MV_NONE, MV_LEFT, MV_RIGHT, MV_HOME}.
  - Function `onehot_of(idx, n)`.
  - Localparam helper for the pos width.
- Sub-module edge_rise:
  - 1-bit rising-edge detector with its own history flop and async reset.
  - Optional 2-flop synchronizer inside under POS_SHIFT_SYNC_EN.
  - Instantiated three times.
- Top holds the pos register, move decode, end checks and counter.

Test Plan:
- Reset with N_POS=4, HOME_POS=0, then 4 right pulses (1 cycle high, 1 low each), WRAP=1 → pos 1,2,3,0; set 0010,0100,1000,0001; move_cnt=4; blocked never high.
- WRAP=0, N_POS=4, from pos 3 pulse right → pos stays 3, at_max=1, blocked high for exactly 1 cycle, move_cnt unchanged. Same check from pos 0 with left.
- Hold right high for 10 cycles → exactly one step (pos 0→1), move_cnt=1.
- Same-cycle edges:
  - left and right rise together → no change.
  - first_pos and right rise together at pos 2 → pos=HOME_POS, move_cnt=0.
- N_POS=8, HOME_POS=5, CNT_W=2: 5 right pulses with WRAP=1 → pos 6,7,0,1,2; move_cnt saturates at 3.
- Assert rst_n low between clock edges at pos 2 → set returns to the HOME_POS one-hot immediately (without waiting for a clk edge). With POS_SHIFT_SYNC_EN defined, verify the output changes 3 cycles after the input.
